imem_fetch_ctrl: RTL

Fetch sequencer for the byte-wide instruction memory. Issues four sequential byte reads per instruction, assembles the 32-bit word big-endian (byte at PC in bits [31:24]), and presents it to decode via valid/ready. It also owns the memory write port during boot so a loader can fill the program image, and handles PC redirects from branch/jump resolution. Sits between the instruction memory array and the decode stage.

---
 rtl/imem_pkg.sv | 25 ++
 rtl/imem_byte_assembler.sv | 36 +++
 rtl/imem_fetch_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch sequencer.
// Pure definitions; no timing or flow-control behaviour of its own.
// Imported by imem_fetch_ctrl and imem_byte_assembler.
package imem_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    localparam int          INST_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // A fetch target must be word aligned and its last byte must sit inside the array.
    function automatic logic pc_in_range(input logic [31:0] pc, input int unsigned addr_w);
        logic [32:0] last_byte;
        logic [32:0] top_byte;
        last_byte = {1'b0, pc} + 33'(INST_BYTES - 1);
        top_byte  = (33'd1 << addr_w) - 33'd1;
        return (pc[1:0] == 2'b00) && (last_byte <= top_byte);
    endfunction

endpackage

// File: rtl/imem_byte_assembler.sv
// Collects four returned memory bytes into one big-endian word (first byte lands in [31:24]).
// Latency: done and the full word are presented combinationally with the fourth byte.
// Backpressure: none; the caller only captures when a byte is known to be on mem_rdata.
module imem_byte_assembler
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        capture_vld,
    input  logic [7:0]  capture_dat,
    output logic [31:0] word_dat,
    output logic        done
);

    logic [1:0]  byte_idx;
    logic [31:0] word_q;

    // Shift-in keeps the earliest byte moving toward the top, so the final word is big-endian.
    assign word_dat = {word_q[23:0], capture_dat};
    assign done     = capture_vld && !clear && (byte_idx == 2'(INST_BYTES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_idx <= 2'd0;
            word_q   <= 32'h0;
        end else if (clear) begin
            byte_idx <= 2'd0;
            word_q   <= 32'h0;
        end else if (capture_vld) begin
            byte_idx <= byte_idx + 2'd1;
            word_q   <= word_dat;
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: boot loader write port, 4-byte sequential fetch, redirect and range fault.
// Latency: inst_valid rises 5 cycles after FETCH entry; one instruction per 6 cycles at best.
// Backpressure: inst_data/inst_pc hold while inst_ready is low; no new fetch until handshake.
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter int          ADDR_W   = 7,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              boot_hold,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_data,
    output logic [31:0]       inst_pc,
    output logic              fault
);

    localparam logic [2:0] ISSUE_CYCLES = 3'(INST_BYTES);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [2:0]   fetch_cyc;

    logic         redirect_act;
    logic         start_vld;
    logic [31:0]  start_pc;
    logic         start_legal;

    logic         asm_clear;
    logic         asm_capture;
    logic         asm_done;
    logic [31:0]  asm_word;

    assign redirect_act = redirect_valid && (state != LOAD);
    assign load_ready   = (state == LOAD);

    // Every way of picking a new pc funnels through here so the range check is applied once.
    always_comb begin
        start_vld = 1'b0;
        start_pc  = pc;
        if (state == LOAD) begin
            if (!boot_hold) begin
                start_vld = 1'b1;
                start_pc  = RESET_PC;
            end
        end else if (redirect_act) begin
            start_vld = 1'b1;
            start_pc  = redirect_pc;
        end else if ((state == HOLD) && inst_ready) begin
            start_vld = 1'b1;
            start_pc  = pc + 32'd4;
        end
    end

    assign start_legal = pc_in_range(start_pc, ADDR_W);

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == LOAD) begin
            mem_we = load_valid;
            if (load_valid) begin
                mem_addr  = load_addr;
                mem_wdata = load_data;
            end
        end else if ((state == FETCH) && (fetch_cyc < ISSUE_CYCLES)) begin
            mem_en   = 1'b1;
            mem_addr = pc[ADDR_W-1:0] + ADDR_W'(fetch_cyc);
        end
    end

    // Read data trails each issue by one cycle, so capture runs on fetch cycles 1..4.
    assign asm_capture = (state == FETCH) && (fetch_cyc != 3'd0);
    assign asm_clear   = redirect_act || (state != FETCH);

    imem_byte_assembler u_asm (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (asm_clear),
        .capture_vld (asm_capture),
        .capture_dat (mem_rdata),
        .word_dat    (asm_word),
        .done        (asm_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= LOAD;
            pc         <= RESET_PC;
            fetch_cyc  <= 3'd0;
            inst_valid <= 1'b0;
            inst_data  <= 32'h0;
            inst_pc    <= 32'h0;
            fault      <= 1'b0;
        end else if (start_vld) begin
            pc         <= start_pc;
            fetch_cyc  <= 3'd0;
            inst_valid <= 1'b0;
            state      <= start_legal ? FETCH : FAULT;
            fault      <= !start_legal;
        end else begin
            case (state)
                FETCH: begin
                    if (asm_done) begin
                        inst_data  <= asm_word;
                        inst_pc    <= pc;
                        inst_valid <= 1'b1;
                        fetch_cyc  <= 3'd0;
                        state      <= HOLD;
                    end else begin
                        fetch_cyc <= fetch_cyc + 3'd1;
                    end
                end
                FAULT: begin
                    inst_valid <= 1'b0;
                    fault      <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
